// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps,
// with the result presented as a one-cycle register-file write-back.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [REGW-1:0] rd,
    output logic            busy,
    output logic            valid,
    output logic            wb_we,
    output logic [REGW-1:0] wb_addr,
    output logic [XLEN-1:0] wb_data
);
    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]            cnt;
    logic [2:0]               op;
    logic [REGW-1:0]          rd_q;
    logic [XLEN-1:0]          a_q;
    logic [XLEN-1:0]          opnd;
    logic [2*XLEN-1:0]        acc;
    logic [2*XLEN-1:0]        acc_nxt;
    logic                     a_neg;
    logic                     b_neg;
    logic                     div0;

    logic                     a_sgn_in;
    logic                     b_sgn_in;
    logic [XLEN-1:0]          a_mag_in;
    logic [XLEN-1:0]          b_mag_in;
    logic [XLEN:0]            sum;
    logic [XLEN:0]            trial;
    logic [XLEN-1:0]          q_mag;
    logic [XLEN-1:0]          r_mag;
    logic signed [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]          result;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    always_comb begin
        a_sgn_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_sgn_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_mag_in = neg_w(a, a_sgn_in && a[XLEN-1]);
        b_mag_in = neg_w(b, b_sgn_in && b[XLEN-1]);
    end

    // acc holds {high half, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        sum     = '0;
        trial   = '0;
        acc_nxt = acc;
        if (!op[2]) begin
            sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
            acc_nxt = {sum, acc[XLEN-1:1]};
        end else begin
            trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
            if (!trial[XLEN]) begin
                acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {acc[2*XLEN-2:0], 1'b0};
            end
        end
    end

    // Signed overflow falls out of the magnitude path (|a|/1, negated); only divide-by-zero needs an override
    always_comb begin
        prod_s = signed'(neg_d(acc_nxt, a_neg ^ b_neg));
        q_mag  = acc_nxt[XLEN-1:0];
        r_mag  = acc_nxt[2*XLEN-1:XLEN];
        result = '0;
        case (op)
            3'b000:                 result = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = div0 ? '1 : neg_w(q_mag, a_neg ^ b_neg);
            default:                result = div0 ? a_q : neg_w(r_mag, a_neg);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            op      <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            opnd    <= '0;
            acc     <= '0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            div0    <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= funct3;
                        rd_q  <= rd;
                        a_q   <= a;
                        a_neg <= a_sgn_in && a[XLEN-1];
                        b_neg <= b_sgn_in && b[XLEN-1];
                        div0  <= (b == '0);
                        opnd  <= funct3[2] ? b_mag_in : a_mag_in;
                        acc   <= {{XLEN{1'b0}}, (funct3[2] ? a_mag_in : b_mag_in)};
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        wb_data <= result;
                        wb_addr <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign valid = (state == DONE);
    assign wb_we = valid && (rd_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases plus random operations against a plain-arithmetic model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        busy;
    logic        valid;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b), .rd(rd),
        .busy(busy), .valid(valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x,
                                               input logic [31:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                p = sx / sy; return p[31:0];
            end
            3'd5: return (y == 32'd0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
                p = sx % sy; return p[31:0];
            end
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at the negedge of the first cycle after the start edge (cycle 1)
    task automatic wait_valid(output int c, output int bl);
        c  = 1;
        bl = 0;
        while (valid !== 1'b1 && c < 40) begin
            if (busy !== 1'b1) bl++;
            @(negedge clk);
            c++;
        end
        if (busy !== 1'b1) bl++;
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, output int c, output int bl);
        @(negedge clk);
        funct3 = f; a = x; b = y; rd = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        funct3 = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
        wait_valid(c, bl);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; funct3 = '0; a = '0; b = '0; rd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", wb_we); end
        checks++; if (wb_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %h want 0", wb_addr); end
        checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", wb_data); end
    endtask

    task automatic test_directed();
        logic [2:0]  vf [14];
        logic [31:0] va [14];
        logic [31:0] vb [14];
        logic [31:0] ve [14];
        int c, bl;
        vf = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        va = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
               32'd100, 32'd100, 32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000,
               32'hFFFFFFF9, 32'hFFFFFFF9};
        vb = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        ve = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
               32'd14, 32'd2, 32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'd0,
               32'hFFFFFFFF, 32'hFFFFFFF9};
        for (int i = 0; i < 14; i++) begin
            do_op(vf[i], va[i], vb[i], 5'(i + 5), c, bl);
            checks++; if (c != 33) begin errors++; $display("FAIL dir%0d_latency got %0d want 33", i, c); end
            checks++; if (bl != 0) begin errors++; $display("FAIL dir%0d_busy low_cycles %0d want 0", i, bl); end
            checks++; if (wb_data !== ve[i]) begin errors++; $display("FAIL dir%0d_data got %h want %h", i, wb_data, ve[i]); end
            checks++; if (wb_addr !== 5'(i + 5)) begin errors++; $display("FAIL dir%0d_addr got %0d want %0d", i, wb_addr, i + 5); end
            checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL dir%0d_we got %b want 1", i, wb_we); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] x, y, exp;
        logic [4:0]  r;
        int c, bl;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom); x = pick(); y = pick(); r = 5'($urandom);
            exp = ref_result(f, x, y);
            do_op(f, x, y, r, c, bl);
            checks++; if (c != 33) begin errors++; $display("FAIL rnd%0d_latency got %0d want 33", i, c); end
            checks++; if (bl != 0) begin errors++; $display("FAIL rnd%0d_busy low_cycles %0d want 0", i, bl); end
            checks++; if (wb_data !== exp) begin errors++; $display("FAIL rnd%0d_data f=%0d a=%h b=%h got %h want %h", i, f, x, y, wb_data, exp); end
            checks++; if (wb_addr !== r) begin errors++; $display("FAIL rnd%0d_addr got %0d want %0d", i, wb_addr, r); end
            checks++; if (wb_we !== (r != 5'd0)) begin errors++; $display("FAIL rnd%0d_we got %b want %b", i, wb_we, (r != 5'd0)); end
        end
    endtask

    task automatic test_rd_zero();
        int c, bl;
        do_op(3'd0, 32'd3, 32'd4, 5'd0, c, bl);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rd0_valid got %b want 1", valid); end
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rd0_we got %b want 0", wb_we); end
        checks++; if (wb_data !== 32'd12) begin errors++; $display("FAIL rd0_data got %h want 0000000c", wb_data); end
    endtask

    task automatic test_ignore_start();
        int pulses, pcyc;
        logic [31:0] got;
        logic [4:0]  gaddr;
        pulses = 0; pcyc = 0; got = '0; gaddr = '0;
        @(negedge clk);
        funct3 = 3'd0; a = 32'd9; b = 32'd5; rd = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 10) begin
                start = 1'b1; funct3 = 3'd5; a = 32'd100; b = 32'd3; rd = 5'd9;
            end else begin
                start = 1'b0;
            end
            if (valid === 1'b1) begin pulses++; pcyc = k; got = wb_data; gaddr = wb_addr; end
            @(negedge clk);
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL ign_pulses got %0d want 1", pulses); end
        checks++; if (pcyc != 33) begin errors++; $display("FAIL ign_cycle got %0d want 33", pcyc); end
        checks++; if (got !== 32'd45) begin errors++; $display("FAIL ign_data got %h want 0000002d", got); end
        checks++; if (gaddr !== 5'd7) begin errors++; $display("FAIL ign_addr got %0d want 7", gaddr); end
        checks++; if (wb_data !== 32'd45) begin errors++; $display("FAIL hold_data got %h want 0000002d", wb_data); end
        checks++; if (wb_addr !== 5'd7) begin errors++; $display("FAIL hold_addr got %0d want 7", wb_addr); end
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL hold_we got %b want 0", wb_we); end
    endtask

    task automatic test_reset_mid();
        int pulses, c, bl;
        pulses = 0;
        @(negedge clk);
        funct3 = 3'd4; a = 32'hFFFFFFF9; b = 32'd2; rd = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", valid); end
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rmid_we got %b want 0", wb_we); end
        checks++; if (wb_addr !== 5'd0) begin errors++; $display("FAIL rmid_addr got %0d want 0", wb_addr); end
        checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL rmid_data got %h want 0", wb_data); end
        for (int k = 0; k < 40; k++) begin
            if (valid === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_pulses got %0d want 0", pulses); end
        rst = 1'b1; start = 1'b1; funct3 = 3'd0; a = 32'd1; b = 32'd1; rd = 5'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %b want 0", busy); end
        do_op(3'd0, 32'd6, 32'd7, 5'd4, c, bl);
        checks++; if (c != 33) begin errors++; $display("FAIL after_rst_latency got %0d want 33", c); end
        checks++; if (wb_data !== 32'd42) begin errors++; $display("FAIL after_rst_data got %h want 0000002a", wb_data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2, e1, e2;
        int c, bl;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = pick();
        e1 = ref_result(3'd3, x1, y1);
        e2 = ref_result(3'd6, x2, y2);
        do_op(3'd3, x1, y1, 5'd12, c, bl);
        checks++; if (c != 33) begin errors++; $display("FAIL b2b1_latency got %0d want 33", c); end
        checks++; if (wb_data !== e1) begin errors++; $display("FAIL b2b1_data got %h want %h", wb_data, e1); end
        funct3 = 3'd6; a = x2; b = y2; rd = 5'd13; start = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
        @(negedge clk);
        start = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
        wait_valid(c, bl);
        checks++; if (c != 33) begin errors++; $display("FAIL b2b2_latency got %0d want 33", c); end
        checks++; if (bl != 0) begin errors++; $display("FAIL b2b2_busy low_cycles %0d want 0", bl); end
        checks++; if (wb_data !== e2) begin errors++; $display("FAIL b2b2_data got %h want %h", wb_data, e2); end
        checks++; if (wb_addr !== 5'd13) begin errors++; $display("FAIL b2b2_addr got %0d want 13", wb_addr); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rd_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
